// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional performance counters (stall/bubble) are built when MEM_WB_PERF_CNT_EN is defined.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_mem_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [REG_AW-1:0] write_reg_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_mem_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_AW-1:0] write_reg_out,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic [DATA_W-1:0] wb_data_out
`ifdef MEM_WB_PERF_CNT_EN
    ,
    input  logic              perf_clr,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data_mem;
        logic [DATA_W-1:0] alu_result;
        logic [REG_AW-1:0] write_reg;
        logic              mem_to_reg;
        logic              reg_write;
    } entry_t;

    state_e state_q, state_d;
    logic   in_ready_q;
    entry_t head_q, skid_q, in_entry;
    logic   accept, deliver;
    logic   load_head_in, load_head_skid, load_skid;

    assign in_entry  = '{data_mem:   data_mem_in,
                         alu_result: alu_result_in,
                         write_reg:  write_reg_in,
                         mem_to_reg: mem_to_reg_in,
                         reg_write:  reg_write_in};
    assign out_valid = (state_q != StEmpty);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign deliver   = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d      = StOne;
                        load_head_in = 1'b1;
                    end
                end
                StOne: begin
                    if (accept && deliver) begin
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        state_d   = StTwo;
                        load_skid = 1'b1;
                    end else if (deliver) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (deliver) begin
                        state_d        = StOne;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // in_ready is a flop so out_ready never reaches the memory stage combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StTwo);
        end
    end

    // Flush clears only control bits; data fields keep their last loaded value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            head_q.mem_to_reg <= 1'b0;
            head_q.reg_write  <= 1'b0;
            skid_q.mem_to_reg <= 1'b0;
            skid_q.reg_write  <= 1'b0;
        end else begin
            if (load_head_in) begin
                head_q <= in_entry;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign data_mem_out   = head_q.data_mem;
    assign alu_result_out = head_q.alu_result;
    assign write_reg_out  = head_q.write_reg;
    assign mem_to_reg_out = head_q.mem_to_reg & out_valid;
    assign reg_write_out  = head_q.reg_write & out_valid;
    assign wb_data_out    = mem_to_reg_out ? head_q.data_mem : head_q.alu_result;

`ifdef MEM_WB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (!out_valid && (bubble_cnt != 16'hFFFF)) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_mem_wb_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data_mem_in = '0;
    logic [DW-1:0] alu_result_in = '0;
    logic [AW-1:0] write_reg_in = '0;
    logic          mem_to_reg_in = 1'b0;
    logic          reg_write_in = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] data_mem_out;
    logic [DW-1:0] alu_result_out;
    logic [AW-1:0] write_reg_out;
    logic          mem_to_reg_out;
    logic          reg_write_out;
    logic [DW-1:0] wb_data_out;
`ifdef MEM_WB_PERF_CNT_EN
    logic          perf_clr = 1'b0;
    logic [15:0]   stall_cnt;
    logic [15:0]   bubble_cnt;
`endif

    mem_wb_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_mem_in    (data_mem_in),
        .alu_result_in  (alu_result_in),
        .write_reg_in   (write_reg_in),
        .mem_to_reg_in  (mem_to_reg_in),
        .reg_write_in   (reg_write_in),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_mem_out   (data_mem_out),
        .alu_result_out (alu_result_out),
        .write_reg_out  (write_reg_out),
        .mem_to_reg_out (mem_to_reg_out),
        .reg_write_out  (reg_write_out),
        .wb_data_out    (wb_data_out)
`ifdef MEM_WB_PERF_CNT_EN
        ,
        .perf_clr       (perf_clr),
        .stall_cnt      (stall_cnt),
        .bubble_cnt     (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two beats plus the registered ready flag.
    typedef struct {
        logic [DW-1:0] data_mem;
        logic [DW-1:0] alu;
        logic [AW-1:0] wreg;
        logic          m2r;
        logic          rw;
    } beat_t;

    beat_t q[$];
    logic  ready_m = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            ready_m = 1'b0;
        end else begin
            automatic bit    acc = in_valid && ready_m;
            automatic bit    del = (q.size() > 0) && out_ready;
            automatic beat_t b;
            b.data_mem = data_mem_in;
            b.alu      = alu_result_in;
            b.wreg     = write_reg_in;
            b.m2r      = mem_to_reg_in;
            b.rw       = reg_write_in;
            if (flush) begin
                q.delete();
            end else begin
                if (del) void'(q.pop_front());
                if (acc) q.push_back(b);
            end
            ready_m = (q.size() != 2);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, ready_m);
            check("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                check("reg_write_out", reg_write_out, q[0].rw);
                check("mem_to_reg_out", mem_to_reg_out, q[0].m2r);
                check("data_mem_out", data_mem_out, q[0].data_mem);
                check("alu_result_out", alu_result_out, q[0].alu);
                check("write_reg_out", write_reg_out, q[0].wreg);
                check("wb_data_out", wb_data_out, q[0].m2r ? q[0].data_mem : q[0].alu);
            end else begin
                check("reg_write_out_idle", reg_write_out, 0);
                check("mem_to_reg_out_idle", mem_to_reg_out, 0);
            end
            if (rst) check("wb_data_out_rst", wb_data_out, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [DW-1:0] dm, input logic [DW-1:0] alu,
                            input logic [AW-1:0] wr, input logic m2r, input logic rw);
        in_valid      = 1'b1;
        data_mem_in   = dm;
        alu_result_in = alu;
        write_reg_in  = wr;
        mem_to_reg_in = m2r;
        reg_write_in  = rw;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wb_data"}, wb_data_out, 0);
        check({tag, "_data_mem"}, data_mem_out, 0);
        check({tag, "_alu"}, alu_result_out, 0);
        check({tag, "_wreg"}, write_reg_out, 0);
        check({tag, "_rw"}, reg_write_out, 0);
        check({tag, "_m2r"}, mem_to_reg_out, 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("in_ready_before_edge", in_ready, 0);
        tick();
        check("in_ready_after_edge", in_ready, 1);

        // Single beat, one-cycle latency.
        out_ready = 1'b1;
        set_beat(16'h0000, 16'h1234, 3'd5, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_wb", wb_data_out, 16'h1234);
        check("single_wreg", write_reg_out, 5);
        check("single_rw", reg_write_out, 1);
        tick();
        check("single_drained", out_valid, 0);

        // Full-throughput stream.
        for (int i = 1; i <= 8; i++) begin
            set_beat(16'h0, DW'(i), AW'(i), 1'b0, 1'b1);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_wb", wb_data_out, i);
            check("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();

        // Backpressure fills the skid entry.
        out_ready = 1'b0;
        set_beat(16'h0, 16'h00AA, 3'd1, 1'b0, 1'b1);
        tick();
        check("bp_a_wb", wb_data_out, 16'h00AA);
        check("bp_a_ready", in_ready, 1);
        set_beat(16'h0, 16'h00BB, 3'd2, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("bp_b_ready", in_ready, 0);
        check("bp_hold_a", wb_data_out, 16'h00AA);
        tick();
        check("bp_hold_a2", wb_data_out, 16'h00AA);
        out_ready = 1'b1;
        tick();
        check("bp_then_b", wb_data_out, 16'h00BB);
        check("bp_ready_back", in_ready, 1);
        tick();
        check("bp_empty", out_valid, 0);

        // Flush from the two-entry state.
        out_ready = 1'b0;
        set_beat(16'h0, 16'h0011, 3'd3, 1'b0, 1'b1);
        tick();
        set_beat(16'h0, 16'h0022, 3'd4, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("pre_flush_full", in_ready, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_rw", reg_write_out, 0);
        check("flush_ready", in_ready, 1);
        set_beat(16'h0, 16'h00CC, 3'd6, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("post_flush_c", wb_data_out, 16'h00CC);
        out_ready = 1'b1;
        tick();
        check("post_flush_alone", out_valid, 0);

        // Memory-data select, then async reset while stalled.
        out_ready = 1'b0;
        set_beat(16'hBEEF, 16'h0040, 3'd7, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        check("m2r_wb", wb_data_out, 16'hBEEF);
        check("m2r_out", mem_to_reg_out, 1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();

`ifdef MEM_WB_PERF_CNT_EN
        out_ready = 1'b0;
        set_beat(16'h0, 16'h0055, 3'd1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        check("perf_clr_stall", stall_cnt, 0);
        repeat (5) tick();
        check("stall_cnt_5", stall_cnt, 5);
        check("bubble_cnt_0", bubble_cnt, 0);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        check("perf_clr_again", stall_cnt, 0);
        out_ready = 1'b1;
        tick();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        repeat (70000) tick();
        check("bubble_sat", bubble_cnt, 16'hFFFF);
        check("stall_idle", stall_cnt, 0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (rst) rst = 1'b0;
            in_valid      = ($urandom_range(9) < 7);
            out_ready     = ($urandom_range(9) < 6);
            flush         = ($urandom_range(19) == 0);
            data_mem_in   = DW'($urandom);
            alu_result_in = DW'($urandom);
            write_reg_in  = AW'($urandom);
            mem_to_reg_in = 1'($urandom);
            reg_write_in  = 1'($urandom);
            if ($urandom_range(399) == 0) rst = 1'b1;
            tick();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
